// File: rtl/array_dump_pkg.sv
// array_dump_pkg: shared state encoding and sizing helpers for array_dump_arbiter
package array_dump_pkg;

    typedef enum logic {
        STATE_IDLE    = 1'b0,
        STATE_SENDING = 1'b1
    } state_t;

    // Number of cells in one array.
    function automatic int array_size(input int height, input int width);
        return height * width;
    endfunction

    // Cell index width, wide enough to hold SIZE without overflow.
    function automatic int index_width(input int size);
        return $clog2(size + 1);
    endfunction

    // Requester index width, never narrower than one bit.
    function automatic int source_width(input int num);
        return (num > 1) ? $clog2(num) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin winner select; fixed priority when ARRAY_DUMP_ARBITER_FIXED_PRIORITY_EN is defined
import array_dump_pkg::*;

module rr_arbiter #(
    parameter int NUM_REQUESTERS = 2,
    parameter int SW             = source_width(NUM_REQUESTERS)
) (
    input  logic [NUM_REQUESTERS-1:0] request,
    input  logic [SW-1:0]             last_grant,
    output logic [NUM_REQUESTERS-1:0] grant,
    output logic [SW-1:0]             grant_index,
    output logic                      any
);

`ifdef ARRAY_DUMP_ARBITER_FIXED_PRIORITY_EN
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    // Search order: lowest index first.
    function automatic int slot(input int i);
        return i;
    endfunction
`else
    // Search order: start just after the previous winner and wrap upward.
    function automatic int slot(input int i);
        return (int'(last_grant) + 1 + i) % NUM_REQUESTERS;
    endfunction
`endif

    // First requesting slot in search order wins.
    always_comb begin
        grant       = '0;
        grant_index = '0;
        any         = 1'b0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (!any && request[slot(i)]) begin
                any               = 1'b1;
                grant[slot(i)]    = 1'b1;
                grant_index       = SW'(slot(i));
            end
        end
    end

endmodule

// File: rtl/array_dump_arbiter.sv
// array_dump_arbiter: arbitrates whole arrays from several producers and streams them cell by cell
// Define ARRAY_DUMP_ARBITER_FIXED_PRIORITY_EN for lowest-index-wins arbitration instead of round-robin.
import array_dump_pkg::*;

module array_dump_arbiter #(
    parameter int NUM_REQUESTERS = 2,
    parameter int ARRAY_HEIGHT   = 2,
    parameter int ARRAY_WIDTH    = 2,
    parameter int CELL_WIDTH     = 8,
    parameter int SIZE           = array_size(ARRAY_HEIGHT, ARRAY_WIDTH),
    parameter int IW             = index_width(SIZE),
    parameter int SW             = source_width(NUM_REQUESTERS)
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic [NUM_REQUESTERS*SIZE*CELL_WIDTH-1:0] in_data,
    input  logic [NUM_REQUESTERS-1:0]               in_valid,
    output logic [NUM_REQUESTERS-1:0]               in_ready,
    output logic [CELL_WIDTH-1:0]                   out_data,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic                                    out_last,
    output logic [SW-1:0]                           out_source
);

    localparam int AW = SIZE * CELL_WIDTH;

    state_t                      state;
    state_t                      next_state;
    logic [IW-1:0]               index;
    logic [AW-1:0]               buffer;
    logic [SW-1:0]               winner;
    logic [SW-1:0]               arb_last;
    logic [NUM_REQUESTERS-1:0]   grant;
    logic [SW-1:0]               grant_index;
    logic                        any;

`ifdef ARRAY_DUMP_ARBITER_FIXED_PRIORITY_EN
    assign arb_last = '0;
`else
    logic [SW-1:0] last_grant;

    // Remember the owner of the last fully delivered array for round-robin rotation.
    always_ff @(posedge clock) begin
        if (reset)
            last_grant <= SW'(NUM_REQUESTERS - 1);
        else if (state == STATE_SENDING && out_ready && out_last)
            last_grant <= winner;
    end

    assign arb_last = last_grant;
`endif

    rr_arbiter #(
        .NUM_REQUESTERS(NUM_REQUESTERS),
        .SW            (SW)
    ) u_arb (
        .request    (in_valid),
        .last_grant (arb_last),
        .grant      (grant),
        .grant_index(grant_index),
        .any        (any)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset)
            state <= STATE_IDLE;
        else
            state <= next_state;
    end

    // Next state and handshake outputs; the stream is driven only while sending.
    always_comb begin
        next_state = state;
        in_ready   = '0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        if (state == STATE_IDLE) begin
            in_ready   = grant;
            next_state = any ? STATE_SENDING : STATE_IDLE;
        end else begin
            out_valid  = 1'b1;
            out_last   = (index == IW'(SIZE - 1));
            next_state = (out_ready && out_last) ? STATE_IDLE : STATE_SENDING;
        end
    end

    // Capture the winner's whole array at grant, then walk the cell index on each accepted cell.
    always_ff @(posedge clock) begin
        if (reset) begin
            index  <= '0;
            buffer <= '0;
            winner <= '0;
        end else if (state == STATE_IDLE && any) begin
            buffer <= in_data[grant_index*AW +: AW];
            winner <= grant_index;
            index  <= '0;
        end else if (state == STATE_SENDING && out_ready) begin
            index  <= out_last ? '0 : index + 1'b1;
        end
    end

    assign out_data   = buffer[index*CELL_WIDTH +: CELL_WIDTH];
    assign out_source = winner;

endmodule

// File: tb/tb_array_dump_arbiter.sv
// tb_array_dump_arbiter: randomized and directed checks of array_dump_arbiter against a transaction-level model
module tb_array_dump_arbiter;

    localparam int N    = 3;
    localparam int SIZE = 4;
    localparam int CW   = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [N*SIZE*CW-1:0] in_data = '0;
    logic [N-1:0]      in_valid = '0;
    logic [N-1:0]      in_ready;
    logic [CW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_last;
    logic [1:0]        out_source;

    logic [N*CW-1:0]   in_data1 = '0;
    logic [N-1:0]      in_valid1 = '0;
    logic [N-1:0]      in_ready1;
    logic [CW-1:0]     out_data1;
    logic              out_valid1;
    logic              out_ready1 = 1'b1;
    logic              out_last1;
    logic [1:0]        out_source1;

    always #5 clock = ~clock;

    array_dump_arbiter #(.NUM_REQUESTERS(N), .ARRAY_HEIGHT(2), .ARRAY_WIDTH(2), .CELL_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .out_source(out_source)
    );

    array_dump_arbiter #(.NUM_REQUESTERS(N), .ARRAY_HEIGHT(1), .ARRAY_WIDTH(1), .CELL_WIDTH(CW)) dut1 (
        .clock(clock), .reset(reset), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1), .out_last(out_last1),
        .out_source(out_source1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: whether an array is in flight, its cells, owner, progress, and the last owner served.
    bit busy = 0;
    int cells[SIZE];
    int src = 0;
    int pos = 0;
    int lg = N - 1;
    int grants[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int last);
`ifdef ARRAY_DUMP_ARBITER_FIXED_PRIORITY_EN
        for (int i = 0; i < N; i++)
            if (v[i]) return i;
`else
        for (int i = 1; i <= N; i++) begin
            int r = (last + i) % N;
            if (v[r]) return r;
        end
`endif
        return -1;
    endfunction

    function automatic int expected_source(input int k);
`ifdef ARRAY_DUMP_ARBITER_FIXED_PRIORITY_EN
        return 0;
`else
        return k % N;
`endif
    endfunction

    task automatic compare();
        int w = pick(in_valid, lg);
        logic [N-1:0] exp_ready = '0;
        if (!busy && w >= 0) exp_ready[w] = 1'b1;
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        check("out_valid", 64'(out_valid), 64'(busy));
        check("out_last", 64'(out_last), 64'(busy && pos == SIZE - 1));
        if (busy) begin
            check("out_data", 64'(out_data), 64'(cells[pos]));
            check("out_source", 64'(out_source), 64'(src));
        end
    endtask

    task automatic advance();
        int w = pick(in_valid, lg);
        if (!busy) begin
            if (w >= 0) begin
                busy = 1;
                src  = w;
                pos  = 0;
                for (int k = 0; k < SIZE; k++) cells[k] = int'(in_data[(w*SIZE+k)*CW +: CW]);
                grants.push_back(w);
            end
        end else if (out_ready) begin
            pos++;
            if (pos == SIZE) begin
                busy = 0;
                lg   = src;
            end
        end
    endtask

    task automatic step();
        @(negedge clock);
        compare();
        advance();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        busy = 0;
        pos  = 0;
        lg   = N - 1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = '0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        @(posedge clock);
        #1;
        do_reset();
        @(negedge clock);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_source", 64'(out_source), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clock);
        #1;

        // Single array from r1, full throughput: SIZE+1 cycles.
        for (int k = 0; k < SIZE; k++) in_data[(SIZE+k)*CW +: CW] = CW'(11 + k);
        in_valid  = 3'b010;
        out_ready = 1'b1;
        step();
        in_valid = '0;
        for (int c = 0; c < SIZE; c++) step();
        @(negedge clock);
        check("tput_idle", 64'(out_valid), 64'd0);
        @(posedge clock);
        #1;

        // All requesting: grant rotation from a fresh reset.
        do_reset();
        grants.delete();
        for (int k = 0; k < N*SIZE; k++) in_data[k*CW +: CW] = CW'($urandom);
        in_valid = 3'b111;
        for (int c = 0; c < 4*(SIZE+1); c++) step();
        check("grant_count", 64'(grants.size()), 64'd4);
        for (int k = 0; k < 4 && k < grants.size(); k++)
            check("grant_order", 64'(grants[k]), 64'(expected_source(k)));

        // Back-pressure mid-array.
        do_reset();
        in_valid  = 3'b001;
        out_ready = 1'b1;
        step();
        in_valid = '0;
        begin
            bit pat[8] = '{1, 0, 0, 1, 1, 1, 1, 1};
            for (int c = 0; c < 8; c++) begin
                out_ready = pat[c];
                step();
            end
        end

        // Reset after cell 1 of an r1 array.
        do_reset();
        in_valid  = 3'b010;
        out_ready = 1'b1;
        step();
        in_valid = '0;
        step();
        step();
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        reset = 1'b0;
        model_reset();
        grants.delete();
        in_valid = 3'b111;
        step();
        check("post_rst_grant", 64'(grants.size() > 0 ? grants[0] : -1), 64'd0);
        for (int c = 0; c < SIZE; c++) step();

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                in_valid  = N'($urandom);
                in_data   = {$urandom, $urandom, $urandom};
                out_ready = ($urandom_range(0, 3) != 0);
                step();
            end
        end

        // Single-cell arrays.
        in_valid  = '0;
        do_reset();
        in_data1  = {8'hA5, 8'h00, 8'h00};
        in_valid1 = 3'b100;
        @(negedge clock);
        check("s1_in_ready", 64'(in_ready1), 64'b100);
        check("s1_idle_valid", 64'(out_valid1), 64'd0);
        @(posedge clock);
        #1;
        in_valid1 = '0;
        @(negedge clock);
        check("s1_valid", 64'(out_valid1), 64'd1);
        check("s1_data", 64'(out_data1), 64'hA5);
        check("s1_last", 64'(out_last1), 64'd1);
        check("s1_source", 64'(out_source1), 64'd2);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("s1_back_idle", 64'(out_valid1), 64'd0);
        check("s1_last_idle", 64'(out_last1), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
